// File: rtl/cordic_hyperbolic_iter.sv
// -----------------------------------------------------------------------------
// cordic_hyperbolic_iter
//
// Purpose:
//   Iterative (one micro-rotation per clock) hyperbolic CORDIC engine.
//   Rotation mode (mode=0) drives z toward 0, producing cosh/sinh-style
//   results in x/y. Vectoring mode (mode=1) drives y toward 0, accumulating
//   atanh(y/x) in z. The atanh angle table lives outside this block. The
//   block presents a shift index on angle_idx, and the table returns
//   atanh(2^-angle_idx) on angle_in in the same cycle.
//
//   Shift sequence over ITERATIONS steps: 1,2,3,4,4,5,...,ITERATIONS-1.
//   Shift 4 is taken twice because hyperbolic CORDIC only converges when
//   certain steps are repeated.
//
// Parameters:
//   FIXED_WIDTH : data/angle width (signed, Q2.14 at the default of 16)
//   ITERATIONS  : number of micro-rotation steps (legal range 5..13)
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   operation request, only looked at while idle
//   mode       in   0 = rotation, 1 = vectoring (captured with start)
//   x_in       in   signed operand x (captured with start)
//   y_in       in   signed operand y (captured with start)
//   z_in       in   signed operand z / angle (captured with start)
//   angle_idx  out  shift index for the external atanh table, 0 when not running
//   angle_in   in   atanh(2^-angle_idx) from the external table (combinational)
//   x_out      out  registered x result, held until the next completion
//   y_out      out  registered y result, held until the next completion
//   z_out      out  registered z result, held until the next completion
//   busy       out  high while an operation is in flight (RUN and DONE)
//   done       out  one-cycle pulse in the cycle the results update
//
// Configuration:
//   CORDIC_HYP_SAT_EN : when defined, the x/y/z updates saturate to the most
//                       positive/negative FIXED_WIDTH value on overflow.
//                       When undefined (default), they wrap modulo
//                       2^FIXED_WIDTH.
// -----------------------------------------------------------------------------
module cordic_hyperbolic_iter #(
    parameter int FIXED_WIDTH = 16,
    parameter int ITERATIONS  = 9
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                mode,
    input  logic signed [FIXED_WIDTH-1:0]       x_in,
    input  logic signed [FIXED_WIDTH-1:0]       y_in,
    input  logic signed [FIXED_WIDTH-1:0]       z_in,
    output logic        [$clog2(ITERATIONS):0]  angle_idx,
    input  logic signed [FIXED_WIDTH-1:0]       angle_in,
    output logic signed [FIXED_WIDTH-1:0]       x_out,
    output logic signed [FIXED_WIDTH-1:0]       y_out,
    output logic signed [FIXED_WIDTH-1:0]       z_out,
    output logic                                busy,
    output logic                                done
);

    localparam int IDX_W = $clog2(ITERATIONS) + 1;
    localparam int CNT_W = $clog2(ITERATIONS);

    localparam logic [CNT_W-1:0] LAST_STEP  = CNT_W'(ITERATIONS - 1);
    localparam logic [IDX_W-1:0] FIRST_SHIFT = IDX_W'(1);
    localparam logic [IDX_W-1:0] REP_SHIFT   = IDX_W'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state;
    logic                          mode_r;
    logic signed [FIXED_WIDTH-1:0] x_r;
    logic signed [FIXED_WIDTH-1:0] y_r;
    logic signed [FIXED_WIDTH-1:0] z_r;
    logic        [CNT_W-1:0]       step_cnt;
    logic        [IDX_W-1:0]       shift_r;
    logic                          rep_done;

    logic                          d_pos;
    logic signed [FIXED_WIDTH-1:0] x_sh;
    logic signed [FIXED_WIDTH-1:0] y_sh;
    logic signed [FIXED_WIDTH-1:0] x_next;
    logic signed [FIXED_WIDTH-1:0] y_next;
    logic signed [FIXED_WIDTH-1:0] z_next;

    // Add (sub=0) or subtract (sub=1) two working values. The result either
    // wraps naturally or clamps at the rails, depending on the build.
    function automatic logic signed [FIXED_WIDTH-1:0] add_sub(
        input logic signed [FIXED_WIDTH-1:0] a,
        input logic signed [FIXED_WIDTH-1:0] b,
        input logic                          sub
    );
`ifdef CORDIC_HYP_SAT_EN
        logic [FIXED_WIDTH:0] s;
        // One guard bit. The top two bits disagree exactly when the true
        // result does not fit, and the guard bit then gives the true sign.
        if (sub) begin
            s = {a[FIXED_WIDTH-1], a} - {b[FIXED_WIDTH-1], b};
        end else begin
            s = {a[FIXED_WIDTH-1], a} + {b[FIXED_WIDTH-1], b};
        end
        if (s[FIXED_WIDTH] != s[FIXED_WIDTH-1]) begin
            if (s[FIXED_WIDTH]) begin
                add_sub = {1'b1, {(FIXED_WIDTH-1){1'b0}}};
            end else begin
                add_sub = {1'b0, {(FIXED_WIDTH-1){1'b1}}};
            end
        end else begin
            add_sub = s[FIXED_WIDTH-1:0];
        end
`else
        if (sub) begin
            add_sub = a - b;
        end else begin
            add_sub = a + b;
        end
`endif
    endfunction

    // The shift register is zero whenever the engine is not running, so it
    // can drive the table index directly.
    assign angle_idx = shift_r;

    // Micro-rotation datapath. d_pos selects d=+1. In rotation mode it
    // follows the sign of the residual angle. In vectoring mode it is set
    // when y is negative, which pushes y back up toward zero. Both x and y
    // use the old (pre-step) values of the other coordinate.
    always_comb begin
        d_pos  = mode_r ? y_r[FIXED_WIDTH-1] : ~z_r[FIXED_WIDTH-1];
        x_sh   = x_r >>> shift_r;
        y_sh   = y_r >>> shift_r;
        x_next = add_sub(x_r, y_sh, ~d_pos);
        y_next = add_sub(y_r, x_sh, ~d_pos);
        z_next = add_sub(z_r, angle_in, d_pos);
    end

    // Control FSM plus all state. IDLE captures operands on start. RUN steps
    // once per clock through the shift sequence and repeats shift 4 once.
    // DONE copies the working registers to the outputs and pulses done.
    // busy drops together with done rising, so a new start can be accepted
    // in that same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mode_r   <= 1'b0;
            x_r      <= '0;
            y_r      <= '0;
            z_r      <= '0;
            step_cnt <= '0;
            shift_r  <= '0;
            rep_done <= 1'b0;
            x_out    <= '0;
            y_out    <= '0;
            z_out    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_r      <= x_in;
                        y_r      <= y_in;
                        z_r      <= z_in;
                        mode_r   <= mode;
                        step_cnt <= '0;
                        shift_r  <= FIRST_SHIFT;
                        rep_done <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    x_r      <= x_next;
                    y_r      <= y_next;
                    z_r      <= z_next;
                    step_cnt <= step_cnt + 1'b1;
                    if (step_cnt == LAST_STEP) begin
                        shift_r <= '0;
                        state   <= DONE;
                    end else if (shift_r == REP_SHIFT && !rep_done) begin
                        rep_done <= 1'b1;
                    end else begin
                        shift_r <= shift_r + 1'b1;
                    end
                end

                DONE: begin
                    x_out <= x_r;
                    y_out <= y_r;
                    z_out <= z_r;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state   <= IDLE;
                    shift_r <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_hyperbolic_iter.sv
// -----------------------------------------------------------------------------
// tb_cordic_hyperbolic_iter
//
// Purpose:
//   Scoreboard bench for cordic_hyperbolic_iter at default parameters.
//   The stimulus pushes the expected results for every accepted operation,
//   along with the cycle in which done must appear. A separate monitor pops
//   one entry and compares it each time done is seen. Expected values come
//   from hand-traced step-by-step runs using the atanh table below.
//   Build option: CORDIC_HYP_SAT_EN selects the saturating expectations for
//   the overflow vector.
// -----------------------------------------------------------------------------
module tb_cordic_hyperbolic_iter;

    localparam int W  = 16;
    localparam int N  = 9;
    localparam int IW = $clog2(N) + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 mode;
    logic signed [W-1:0]  x_in;
    logic signed [W-1:0]  y_in;
    logic signed [W-1:0]  z_in;
    logic        [IW-1:0] angle_idx;
    logic signed [W-1:0]  angle_in;
    logic signed [W-1:0]  x_out;
    logic signed [W-1:0]  y_out;
    logic signed [W-1:0]  z_out;
    logic                 busy;
    logic                 done;

    typedef struct {
        int x;
        int y;
        int z;
        int due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   shift_tbl[N] = '{1, 2, 3, 4, 4, 5, 6, 7, 8};

    cordic_hyperbolic_iter #(
        .FIXED_WIDTH(W),
        .ITERATIONS (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .x_in     (x_in),
        .y_in     (y_in),
        .z_in     (z_in),
        .angle_idx(angle_idx),
        .angle_in (angle_in),
        .x_out    (x_out),
        .y_out    (y_out),
        .z_out    (z_out),
        .busy     (busy),
        .done     (done)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Edge counter used for the latency check.
    always @(posedge clk) cyc <= cyc + 1;

    // atanh(2^-i) in Q2.14, rounded to nearest.
    function automatic logic signed [W-1:0] rom_lookup(input logic [IW-1:0] idx);
        case (idx)
            5'd1:    rom_lookup = 16'sd9000;
            5'd2:    rom_lookup = 16'sd4185;
            5'd3:    rom_lookup = 16'sd2059;
            5'd4:    rom_lookup = 16'sd1025;
            5'd5:    rom_lookup = 16'sd512;
            5'd6:    rom_lookup = 16'sd256;
            5'd7:    rom_lookup = 16'sd128;
            5'd8:    rom_lookup = 16'sd64;
            5'd9:    rom_lookup = 16'sd32;
            5'd10:   rom_lookup = 16'sd16;
            5'd11:   rom_lookup = 16'sd8;
            5'd12:   rom_lookup = 16'sd4;
            default: rom_lookup = 16'sd0;
        endcase
    endfunction

    // External angle table, answering in the same cycle.
    always_comb angle_in = rom_lookup(angle_idx);

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Called at a falling edge. Waits for idle, presents one start pulse and,
    // if a completion is expected, queues its results and due cycle. Returns
    // at the falling edge right after the edge that sampled start.
    task automatic applyStimulus(input logic m, input int xi, input int yi, input int zi,
                                 input int ex, input int ey, input int ez, input bit expect_done);
        int waited;
        exp_t e;
        waited = 0;
        while (busy && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (busy) checkOutput("idle_wait_timeout", 1, 0);
        mode  = m;
        x_in  = W'(xi);
        y_in  = W'(yi);
        z_in  = W'(zi);
        start = 1'b1;
        if (expect_done) begin
            e.x   = ex;
            e.y   = ey;
            e.z   = ez;
            e.due = cyc + 2 + N;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_x_out"}, x_out, 0);
        checkOutput({tag, "_y_out"}, y_out, 0);
        checkOutput({tag, "_z_out"}, z_out, 0);
        checkOutput({tag, "_angle_idx"}, angle_idx, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    // Hard stop in case something upstream hangs.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence. The monitor runs alongside it, in its own
    // forked process.
    initial begin
        int   w;
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        x_in  = '0;
        y_in  = '0;
        z_in  = '0;

        fork
            forever begin
                @(negedge clk);
                if (done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_done: got done=1, expected no done");
                    end else begin
                        e = sb.pop_front();
                        checkOutput("x_out", x_out, e.x);
                        checkOutput("y_out", y_out, e.y);
                        checkOutput("z_out", z_out, e.z);
                        checkOutput("done_cycle", cyc, e.due);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;

        // Rotation cosh/sinh(0.5), issued in the first cycle out of reset.
        // Also traces the table index through the whole run.
        $display("[TB] rotation x=19784 y=0 z=8192 with angle_idx trace");
        applyStimulus(1'b0, 19784, 0, 8192, 18490, 8569, -28, 1'b1);
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("angle_idx_run%0d", i), angle_idx, shift_tbl[i]);
            if (i == 0) checkOutput("busy_run", busy, 1);
            @(negedge clk);
        end
        checkOutput("angle_idx_done_state", angle_idx, 0);
        checkOutput("busy_done_state", busy, 1);
        checkOutput("done_early", done, 0);
        @(negedge clk);
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_after", busy, 0);
        checkOutput("angle_idx_idle", angle_idx, 0);

        // Vectoring atanh(0.5), started in the same cycle as the previous done.
        $display("[TB] vectoring x=16384 y=8192 z=0 back-to-back");
        applyStimulus(1'b1, 16384, 8192, 0, 11751, -6, 9012, 1'b1);

        // Overflow vector, again back-to-back. The sums wrap on the first
        // steps. With saturation enabled, x/y first pin at 32767. The later
        // d=-1 steps then pull them back down to 30883.
        $display("[TB] overflow x=32767 y=32767 z=16384");
`ifdef CORDIC_HYP_SAT_EN
        applyStimulus(1'b0, 32767, 32767, 16384, 30883, 30883, 50, 1'b1);
`else
        applyStimulus(1'b0, 32767, 32767, 16384, -24518, -24518, 50, 1'b1);
`endif

        // Start during RUN cycle 3 with other operands must be ignored.
        $display("[TB] start while busy is ignored");
        applyStimulus(1'b0, 19784, 0, 8192, 18490, 8569, -28, 1'b1);
        repeat (2) @(negedge clk);
        mode  = 1'b1;
        x_in  = 16'sd16384;
        y_in  = 16'sd8192;
        z_in  = 16'sd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Reset at RUN cycle 5 clears everything, and no done follows.
        $display("[TB] reset abort mid-run");
        applyStimulus(1'b1, 16384, 8192, 0, 0, 0, 0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkResetState("abort");
        rst = 1'b0;
        repeat (15) @(negedge clk);
        applyStimulus(1'b1, 16384, 8192, 0, 11751, -6, 9012, 1'b1);

        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
